gray_counter: RTL and testbench
===============================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter RESET_VAL, default 0: binary count value applied on reset and clear.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 arst_ni  in  1  reset, asynchronous, active-low.
REQ-005 clear_i  in  1  synchronous clear to RESET_VAL.
REQ-006 load_i  in  1  synchronous load from load_gray_i.
REQ-007 load_gray_i  in  WIDTH  load value, Gray-coded.
REQ-008 en_i  in  1  count enable.
REQ-009 dir_i  in  1  count direction: 1 up, 0 down.
REQ-010 bin_o  out  WIDTH  registered binary count.
REQ-011 gray_o  out  WIDTH  registered Gray count, driven directly from flops.
REQ-012 gray_next_o  out  WIDTH  combinational Gray value to be registered at the next edge.
REQ-013 wrap_o  out  1  registered one-cycle pulse on wrap-around.
REQ-014 tc_o  out  1  combinational terminal count.

Function
REQ-015 Command priority per cycle SHALL be clear_i > load_i > en_i > hold.
REQ-016 Clear: bin_o <= RESET_VAL, gray_o <= Gray(RESET_VAL), wrap_o <= 0.
REQ-017 Load: bin_o <= Bin(load_gray_i), gray_o <= load_gray_i, wrap_o <= 0.
REQ-018 Count: bin_o <= bin_o+1 if dir_i=1, else bin_o-1, modulo 2^WIDTH; gray_o <= Gray(new bin).
REQ-019 Hold: bin_o, gray_o unchanged, wrap_o <= 0.
REQ-020 Latency: every command visible on bin_o/gray_o exactly one clock after the sampling edge.
REQ-021 Gray(b) = b XOR (b>>1); Bin(g) bit i = XOR of g[WIDTH-1:i].
REQ-022 gray_o SHALL change in at most one bit per count step, including wrap; no combinational path to gray_o.
REQ-023 gray_next_o SHALL equal the value gray_o takes at the next edge under the current inputs, including clear and load.
REQ-024 tc_o = 1 when (dir_i=1 and bin_o=2^WIDTH-1) or (dir_i=0 and bin_o=0), independent of en_i.
REQ-025 wrap_o SHALL pulse for one cycle, coincident with the new value, when a count step takes 2^WIDTH-1 -> 0 (up) or 0 -> 2^WIDTH-1 (down).
REQ-026 dir_i changing between cycles SHALL take effect on the next counted step, with no lost or extra step.

Reset
REQ-027 arst_ni low SHALL immediately force bin_o=RESET_VAL, gray_o=Gray(RESET_VAL), wrap_o=0, regardless of clk_i.
REQ-028 Assertion mid-count SHALL abandon the step in progress. Counting resumes on the first rising edge after deassertion with en_i=1.

Configuration
REQ-029 Macro GRAY_COUNTER_SAT_EN defined: a count step at tc_o=1 SHALL hold the value, and wrap_o SHALL stay 0.
REQ-030 Macro GRAY_COUNTER_SAT_EN undefined: wrap-around per REQ-018/REQ-025; load and clear are unaffected either way.

Structure
REQ-031 Package gray_counter_pkg SHALL hold the count-direction typedef (UP=1, DOWN=0) and the WIDTH min/max constants.
REQ-032 Sub-module gray_2_bin (parameter WIDTH, purely combinational) SHALL be instantiated for Bin(load_gray_i).
REQ-033 Gray encoding of the next value SHALL be computed once and shared by gray_next_o and the gray_o register.

Verification (WIDTH=4, RESET_VAL=0 unless stated)
REQ-034 Reset then 16 cycles en_i=1, dir_i=1 -> gray_o steps 0,1,3,2,6,...,8,0; wrap_o=1 only on the 15->0 step; one-bit change every step.
REQ-035 Down count from bin 1 with en_i=1, dir_i=0 -> bin 0 with tc_o=1, then bin 15/gray 8 with wrap_o=1; with GRAY_COUNTER_SAT_EN, holds at 0 and wrap_o=0.
REQ-036 Same cycle clear_i=1, load_i=1 (load_gray_i=4'hC), en_i=1 -> bin_o=0. Next cycle load_i=1 only -> gray_o=4'hC, bin_o=8.
REQ-037 arst_ni pulsed low between edges at bin 9 -> outputs 0 before the next edge; with RESET_VAL=5, gray_o=4'h7.
REQ-038 Random en_i/dir_i/load_i for 10k cycles -> scoreboard matches bin_o, gray_o, and gray_next_o equals the next-cycle gray_o.

Source files
------------

// File: rtl/gray_counter_pkg.sv
// Shared types and limits for the Gray-code counter.
package gray_counter_pkg;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } count_dir_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/gray_2_bin.sv
// Combinational Gray-to-binary converter: bin[i] is the XOR of gray[WIDTH-1:i].
module gray_2_bin #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray counter with clear, Gray-coded load and terminal count.
// Define GRAY_COUNTER_SAT_EN to saturate at the terminal count instead of wrapping.
module gray_counter
    import gray_counter_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_gray_i,
    input  logic             en_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] gray_o,
    output logic [WIDTH-1:0] gray_next_o,
    output logic             wrap_o,
    output logic             tc_o
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("gray_counter: WIDTH out of range");
    end

    localparam logic [WIDTH-1:0] RST_BIN  = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    count_dir_e       dir;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin_step;
    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             wrap_nxt;
    logic             tc;

    gray_2_bin #(.WIDTH(WIDTH)) u_load_conv (
        .gray (load_gray_i),
        .bin  (load_bin)
    );

    assign dir      = count_dir_e'(dir_i);
    assign tc       = (dir == UP) ? (bin_q == '1) : (bin_q == '0);
    assign bin_step = (dir == UP) ? bin_q + 1'b1 : bin_q - 1'b1;

    always_comb begin
        bin_nxt  = bin_q;
        wrap_nxt = 1'b0;
        if (clear_i) begin
            bin_nxt = RST_BIN;
        end else if (load_i) begin
            bin_nxt = load_bin;
        end else if (en_i) begin
`ifdef GRAY_COUNTER_SAT_EN
            if (!tc) begin
                bin_nxt = bin_step;
            end
`else
            bin_nxt  = bin_step;
            wrap_nxt = tc;
`endif
        end
    end

    // Single Gray encoder feeds both the look-ahead output and the register;
    // on load it reproduces load_gray_i exactly.
    assign gray_nxt = bin_nxt ^ (bin_nxt >> 1);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_nxt;
            gray_q <= gray_nxt;
            wrap_q <= wrap_nxt;
        end
    end

    assign bin_o       = bin_q;
    assign gray_o      = gray_q;
    assign wrap_o      = wrap_q;
    assign gray_next_o = gray_nxt;
    assign tc_o        = tc;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter (WIDTH=4) against an arithmetic reference model.
module tb_gray_counter;

    localparam int W   = 4;
    localparam int MOD = 16;

    logic         clk_i = 1'b0;
    logic         arst_ni = 1'b0;
    logic         clear_i = 1'b0;
    logic         load_i = 1'b0;
    logic [W-1:0] load_gray_i = '0;
    logic         en_i = 1'b0;
    logic         dir_i = 1'b1;
    logic [W-1:0] bin_o, gray_o, gray_next_o;
    logic         wrap_o, tc_o;
    logic [W-1:0] bin5, gray5, gray_next5;
    logic         wrap5, tc5;

    gray_counter #(.WIDTH(W), .RESET_VAL(32'd0)) dut (
        .clk_i(clk_i), .arst_ni(arst_ni), .clear_i(clear_i), .load_i(load_i),
        .load_gray_i(load_gray_i), .en_i(en_i), .dir_i(dir_i),
        .bin_o(bin_o), .gray_o(gray_o), .gray_next_o(gray_next_o),
        .wrap_o(wrap_o), .tc_o(tc_o)
    );

    gray_counter #(.WIDTH(W), .RESET_VAL(32'd5)) dut5 (
        .clk_i(clk_i), .arst_ni(arst_ni), .clear_i(clear_i), .load_i(load_i),
        .load_gray_i(load_gray_i), .en_i(en_i), .dir_i(dir_i),
        .bin_o(bin5), .gray_o(gray5), .gray_next_o(gray_next5),
        .wrap_o(wrap5), .tc_o(tc5)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int bin;
        int gray;
        int wrap;
        bit step;
        int prev_gray;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   m = 0;
`ifdef GRAY_COUNTER_SAT_EN
    bit   sat = 1'b1;
`else
    bit   sat = 1'b0;
`endif

    function automatic int gray_of(int b);
        return b ^ (b >> 1);
    endfunction

    // Inverse Gray by table search rather than by bit formula.
    function automatic int bin_of_gray(int g);
        for (int b = 0; b < MOD; b++) begin
            if (gray_of(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit c, input bit l, input int lg, input bit e, input bit d);
        int   nm;
        int   w;
        bit   tc_exp;
        exp_t x;
        @(negedge clk_i);
        clear_i     = c;
        load_i      = l;
        load_gray_i = lg[W-1:0];
        en_i        = e;
        dir_i       = d;
        #1;
        tc_exp = (d && m == MOD - 1) || (!d && m == 0);
        nm = m;
        w  = 0;
        if (c) nm = 0;
        else if (l) nm = bin_of_gray(lg);
        else if (e) begin
            if (!(sat && tc_exp)) begin
                nm = d ? (m + 1) % MOD : (m + MOD - 1) % MOD;
                w  = tc_exp ? 1 : 0;
            end
        end
        chk("tc_o", int'(tc_o), int'(tc_exp));
        chk("gray_next_o", int'(gray_next_o), gray_of(nm));
        x.bin = nm;
        x.gray = gray_of(nm);
        x.wrap = w;
        x.step = !c && !l && e && (nm != m);
        x.prev_gray = gray_of(m);
        q.push_back(x);
        m = nm;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk_i);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("bin_o", int'(bin_o), x.bin);
                chk("gray_o", int'(gray_o), x.gray);
                chk("wrap_o", int'(wrap_o), x.wrap);
                if (x.step) chk("gray_one_bit", $countones(gray_o ^ x.prev_gray[W-1:0]), 1);
            end
        end
    end

    task automatic pulse_reset();
        @(negedge clk_i);
        clear_i = 1'b0;
        load_i  = 1'b0;
        en_i    = 1'b1;
        #2 arst_ni = 1'b0;
        #1;
        chk("rst_bin", int'(bin_o), 0);
        chk("rst_gray", int'(gray_o), 0);
        chk("rst_wrap", int'(wrap_o), 0);
        chk("rst5_bin", int'(bin5), 5);
        chk("rst5_gray", int'(gray5), 7);
        en_i = 1'b0;
        #1 arst_ni = 1'b1;
        m = 0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin : stim
        #12;
        chk("init_bin", int'(bin_o), 0);
        chk("init_gray", int'(gray_o), 0);
        chk("init_wrap", int'(wrap_o), 0);
        chk("init5_gray", int'(gray5), 7);
        @(negedge clk_i);
        arst_ni = 1'b1;
        m = 0;

        // Full up-count cycle including the 15 -> 0 wrap.
        for (int i = 0; i < MOD; i++) drive(0, 0, 0, 1, 1);

        // Down count through zero starting at bin 1.
        drive(0, 1, gray_of(1), 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);

        // Clear beats load and enable; then load alone.
        drive(1, 1, 'hC, 1, 1);
        drive(0, 1, 'hC, 1, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);

        // Reset between edges while sitting at bin 9, then resume counting.
        drive(0, 1, gray_of(9), 0, 1);
        pulse_reset();
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 1);

        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, MOD - 1)), $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)));
        end

        @(negedge clk_i);
        clear_i = 1'b0;
        load_i  = 1'b0;
        en_i    = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
